// File: rtl/pe_output_writer_pkg.sv
// Shared definitions for the pe array output writer: word geometry,
// FSM state encodings and the state enum used by the top level.
`ifndef PE_OUTPUT_WRITER_DEFS
`define PE_OUTPUT_WRITER_DEFS
`define DATA_WIDTH 8
`define WORD_WIDTH 32
`define OUTPUT_LAT 2
`define PE_OW_IDLE 2'd0
`define PE_OW_RUN 2'd1
`define PE_OW_DONE 2'd2
`endif

package pe_output_writer_pkg;

  // Width of one assembled pe array output word.
  localparam int unsigned WORD_W = `WORD_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = `PE_OW_IDLE,
    ST_RUN  = `PE_OW_RUN,
    ST_DONE = `PE_OW_DONE
  } state_e;

endpackage

// File: rtl/pe_output_writer_strobe_delay.sv
// Single-bit delay line: a column's write strobe delayed by DEPTH cycles,
// so its output marks the cycle in which the column's word is final.
module strobe_delay #(
  parameter int unsigned DEPTH = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] shift_d;

  // Next shift state: move every stage up by one and insert the new strobe.
  always_comb begin
    shift_d    = shift_q << 1;
    shift_d[0] = d_i;
  end

  // Shift register stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q_o = shift_q[DEPTH-1];

endmodule

// File: rtl/pe_output_writer.sv
// Drain stage for the pe arrays: captures each column's word once its
// delayed strobe says it is final, parks it in a per-column hold register,
// and streams pending words one per cycle into the output global buffer at
// consecutive addresses, honouring buffer back-pressure. Completion is
// signalled after a programmed number of accepted writes.
module pe_output_writer
  import pe_output_writer_pkg::*;
#(
  parameter int unsigned NUM_ARRAYS = 8,
  parameter int unsigned WORD_LAT   = 8 + `OUTPUT_LAT,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [ADDR_WIDTH-1:0]        base_addr_i,
  input  logic [CNT_WIDTH-1:0]         num_words_i,
  input  logic [NUM_ARRAYS-1:0]        we_i,
  input  logic [NUM_ARRAYS*WORD_W-1:0] word_i,
  output logic                         wr_en_o,
  output logic [ADDR_WIDTH-1:0]        wr_addr_o,
  output logic [WORD_W-1:0]            wr_data_o,
  input  logic                         wr_ready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o
);

  localparam int unsigned IDX_W = (NUM_ARRAYS > 1) ? $clog2(NUM_ARRAYS) : 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  tgt_q, tgt_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  overflow_q, overflow_d;
  logic                  wr_en_q, wr_en_d;
  logic [WORD_W-1:0]     wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [NUM_ARRAYS-1:0] pend_q, pend_d;
  logic                  clr_pend;

  logic [WORD_W-1:0]     hold_q [NUM_ARRAYS];
  logic [NUM_ARRAYS-1:0] cap;
  logic [NUM_ARRAYS-1:0] cap_run;
  logic [NUM_ARRAYS-1:0] hold_load;
  logic [NUM_ARRAYS-1:0] lost;
  logic [NUM_ARRAYS-1:0] drain_vec;
  logic [IDX_W-1:0]      sel;
  logic                  in_run;
  logic                  accept;
  logic                  out_free;
  logic                  drain;

  assign in_run   = (state_q == ST_RUN);
  assign accept   = wr_en_q & wr_ready_i;
  // The output stage can take a new word when empty or when its word leaves now.
  assign out_free = ~wr_en_q | wr_ready_i;
  assign drain    = in_run & out_free & (|pend_q);
  assign cnt_inc  = cnt_q + CNT_WIDTH'(1);

  // Lowest-index pending column wins the output stage.
  always_comb begin
    sel = '0;
    for (int i = NUM_ARRAYS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel = IDX_W'(i);
      end
    end
  end

  // One-hot marker of the column being drained this cycle.
  always_comb begin
    drain_vec = '0;
    if (drain) begin
      drain_vec[sel] = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_ARRAYS; gi++) begin : g_col
    strobe_delay #(
      .DEPTH(WORD_LAT)
    ) u_strobe_delay (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (we_i[gi]),
      .q_o   (cap[gi])
    );

    // A capture lands if the slot is free or is being emptied this same cycle;
    // otherwise the earlier pending word is kept and the new one is lost.
    assign cap_run[gi]   = in_run & cap[gi];
    assign hold_load[gi] = cap_run[gi] & (~pend_q[gi] | drain_vec[gi]);
    assign lost[gi]      = cap_run[gi] & pend_q[gi] & ~drain_vec[gi];
    assign pend_d[gi]    = cap_run[gi] | (pend_q[gi] & ~drain_vec[gi]);

    // Per-column hold register for a captured, not yet drained word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hold_q[gi] <= '0;
      end else if (hold_load[gi]) begin
        hold_q[gi] <= word_i[gi*WORD_W +: WORD_W];
      end
    end
  end

  // Control FSM plus output stage, address and count next-state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    wr_en_d    = wr_en_q;
    wr_data_d  = wr_data_q;
    clr_pend   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d     = base_addr_i;
          tgt_d      = num_words_i;
          cnt_d      = '0;
          overflow_d = 1'b0;
          clr_pend   = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (|lost) begin
          overflow_d = 1'b1;
        end
        if (accept) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          cnt_d   = cnt_inc;
          wr_en_d = 1'b0;
        end
        if (drain) begin
          wr_en_d   = 1'b1;
          wr_data_d = hold_q[sel];
        end
        // Completion discards whatever is still queued or staged.
        if ((tgt_q == '0) || (accept && (cnt_inc == tgt_q))) begin
          state_d  = ST_DONE;
          wr_en_d  = 1'b0;
          clr_pend = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, counters, pending flags and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      tgt_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pend_q     <= clr_pend ? '0 : pend_d;
    end
  end

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = overflow_q;

endmodule
